// File: rtl/spi_seq_pkg.sv
// Shared types and helpers for the SPI register-transaction sequencer.
// Defines the FSM state encoding, header bit positions and the header builder.

package spi_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HDR     = 3'd1,
        ST_WR_WAIT = 3'd2,
        ST_WR_REQ  = 3'd3,
        ST_RD_REQ  = 3'd4,
        ST_RD_WAIT = 3'd5,
        ST_DRAIN   = 3'd6
    } state_t;

    // Header byte layout: bit7 = read, bit6 = multi-byte burst, bits5:0 = register address
    localparam int HDR_READ_BIT  = 7;
    localparam int HDR_MULTI_BIT = 6;

    function automatic logic [7:0] build_header(input logic       is_read,
                                                input logic       is_multi,
                                                input logic [5:0] addr);
        logic [7:0] hdr;
        hdr                = {2'b00, addr};
        hdr[HDR_READ_BIT]  = is_read;
        hdr[HDR_MULTI_BIT] = is_multi;
        return hdr;
    endfunction

endpackage

// File: rtl/spi_seq_watchdog.sv
// Per-state watchdog for the SPI register sequencer.
// Only built when SPI_SEQ_TIMEOUT_EN is defined; the sequencer instantiates it only then.
// The counter restarts on clear (state change) and flags expiry on the LIMIT-th counted cycle.

`ifdef SPI_SEQ_TIMEOUT_EN
module spi_seq_watchdog #(
    parameter  int LIMIT = 4096,
    localparam int CNT_W = $clog2(LIMIT + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    logic [CNT_W-1:0] count;

    assign expired = count_en && (count == CNT_W'(LIMIT - 1));

    // Cycle counter: restarts on every state change, holds once the limit is hit
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (count_en && !expired) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule
`endif

// File: rtl/spi_reg_sequencer.sv
// Register-transaction sequencer placed in front of the byte-level SPI master.
// Accepts one read/write command, sends the header byte, streams the payload bytes
// through the tx/rx request handshake, then waits for CSN to release before done.
// Optional feature macro: SPI_SEQ_TIMEOUT_EN (adds the per-state watchdog and sticky error).

module spi_reg_sequencer
    import spi_seq_pkg::*;
#(
    parameter  int MAX_BURST      = 8,
`ifdef SPI_SEQ_TIMEOUT_EN
    parameter  int TIMEOUT_CYCLES = 4096,
`endif
    localparam int LEN_W          = $clog2(MAX_BURST + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_read,
    input  logic [5:0]       cmd_addr,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             wr_valid,
    input  logic [7:0]       wr_data,
    output logic             wr_ready,
    output logic             rd_valid,
    output logic [7:0]       rd_data,
    output logic             rd_last,
    output logic             done,
    output logic             error,
    output logic             spi_tx_request,
    output logic [7:0]       spi_tx_data,
    output logic             spi_rx_request,
    input  logic             spi_ack_request,
    input  logic [7:0]       spi_rx_data,
    input  logic             spi_rx_valid,
    input  logic             spi_active
);

    state_t           state;
    state_t           state_next;
    logic [LEN_W-1:0] remaining;
    logic [LEN_W-1:0] len_eff;
    logic             is_read_q;
    logic [7:0]       tx_data_q;
    logic             rd_valid_q;
    logic [7:0]       rd_data_q;
    logic             rd_last_q;
    logic             last_byte;
    logic             cmd_accept;
    logic             wr_take;
    logic             wr_acked;
    logic             rd_capture;
    logic             expired;

    assign last_byte      = (remaining == LEN_W'(1));
    assign spi_tx_data    = tx_data_q;
    assign rd_valid       = rd_valid_q;
    assign rd_data        = rd_data_q;
    assign rd_last        = rd_last_q;
    assign wr_ready       = wr_take;

    // Effective burst length: zero means one byte, anything above the maximum is clamped
    always_comb begin
        len_eff = cmd_len;
        if (cmd_len == '0) begin
            len_eff = LEN_W'(1);
        end else if (int'(cmd_len) > MAX_BURST) begin
            len_eff = LEN_W'(MAX_BURST);
        end
    end

`ifdef SPI_SEQ_TIMEOUT_EN
    logic wd_count_en;
    logic error_q;

    assign wd_count_en = (state == ST_HDR)     || (state == ST_WR_REQ) ||
                         (state == ST_RD_REQ)  || (state == ST_RD_WAIT) ||
                         (state == ST_DRAIN);
    assign error       = error_q;

    spi_seq_watchdog #(
        .LIMIT    (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk      (clk),
        .reset    (reset),
        .clear    (state_next != state),
        .count_en (wd_count_en),
        .expired  (expired)
    );

    // Sticky timeout flag, cleared only by reset
    always_ff @(posedge clk) begin
        if (reset) begin
            error_q <= 1'b0;
        end else if (expired) begin
            error_q <= 1'b1;
        end
    end
`else
    assign expired = 1'b0;
    assign error   = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and handshake outputs; a watchdog expiry overrides everything
    always_comb begin
        state_next     = state;
        cmd_ready      = 1'b0;
        cmd_accept     = 1'b0;
        spi_tx_request = 1'b0;
        spi_rx_request = 1'b0;
        wr_take        = 1'b0;
        wr_acked       = 1'b0;
        rd_capture     = 1'b0;
        done           = 1'b0;
        case (state)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    cmd_accept = 1'b1;
                    state_next = ST_HDR;
                end
            end
            ST_HDR: begin
                spi_tx_request = 1'b1;
                if (spi_ack_request) begin
                    state_next = is_read_q ? ST_RD_REQ : ST_WR_WAIT;
                end
            end
            ST_WR_WAIT: begin
                if (wr_valid) begin
                    wr_take    = 1'b1;
                    state_next = ST_WR_REQ;
                end
            end
            ST_WR_REQ: begin
                spi_tx_request = 1'b1;
                if (spi_ack_request) begin
                    wr_acked   = 1'b1;
                    state_next = last_byte ? ST_DRAIN : ST_WR_WAIT;
                end
            end
            ST_RD_REQ: begin
                spi_rx_request = 1'b1;
                if (spi_ack_request) begin
                    state_next = ST_RD_WAIT;
                end
            end
            ST_RD_WAIT: begin
                if (spi_rx_valid) begin
                    rd_capture = 1'b1;
                    state_next = last_byte ? ST_DRAIN : ST_RD_REQ;
                end
            end
            ST_DRAIN: begin
                if (!spi_active) begin
                    done       = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
        if (expired) begin
            state_next     = ST_IDLE;
            spi_tx_request = 1'b0;
            spi_rx_request = 1'b0;
            wr_take        = 1'b0;
            wr_acked       = 1'b0;
            rd_capture     = 1'b0;
            done           = 1'b1;
        end
    end

    // Command latch, byte counter, tx byte holding register and read-data pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            remaining  <= '0;
            is_read_q  <= 1'b0;
            tx_data_q  <= 8'h00;
            rd_valid_q <= 1'b0;
            rd_data_q  <= 8'h00;
            rd_last_q  <= 1'b0;
        end else begin
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
            if (cmd_accept) begin
                remaining <= len_eff;
                is_read_q <= cmd_read;
                tx_data_q <= build_header(cmd_read, (len_eff > LEN_W'(1)), cmd_addr);
            end
            if (wr_take) begin
                tx_data_q <= wr_data;
            end
            if (wr_acked) begin
                remaining <= remaining - LEN_W'(1);
            end
            if (rd_capture) begin
                rd_valid_q <= 1'b1;
                rd_data_q  <= spi_rx_data;
                rd_last_q  <= last_byte;
                remaining  <= remaining - LEN_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_spi_reg_sequencer.sv
// Directed self-checking bench for spi_reg_sequencer.
// The bench itself plays the SPI master side (ack, rx data, active/CSN).
// With SPI_SEQ_TIMEOUT_EN defined it additionally exercises the watchdog timeout.

module tb_spi_reg_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_read;
    logic [5:0] cmd_addr;
    logic [3:0] cmd_len;
    logic       wr_valid;
    logic [7:0] wr_data;
    logic       wr_ready;
    logic       rd_valid;
    logic [7:0] rd_data;
    logic       rd_last;
    logic       done;
    logic       error;
    logic       spi_tx_request;
    logic [7:0] spi_tx_data;
    logic       spi_rx_request;
    logic       spi_ack_request;
    logic [7:0] spi_rx_data;
    logic       spi_rx_valid;
    logic       spi_active;

    int checks = 0;
    int errors = 0;
    int wr_cnt = 0;
    int rdv_cnt = 0;
    int rdl_cnt = 0;
    int done_cnt = 0;

    spi_reg_sequencer dut (
        .clk             (clk),
        .reset           (reset),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_read        (cmd_read),
        .cmd_addr        (cmd_addr),
        .cmd_len         (cmd_len),
        .wr_valid        (wr_valid),
        .wr_data         (wr_data),
        .wr_ready        (wr_ready),
        .rd_valid        (rd_valid),
        .rd_data         (rd_data),
        .rd_last         (rd_last),
        .done            (done),
        .error           (error),
        .spi_tx_request  (spi_tx_request),
        .spi_tx_data     (spi_tx_data),
        .spi_rx_request  (spi_rx_request),
        .spi_ack_request (spi_ack_request),
        .spi_rx_data     (spi_rx_data),
        .spi_rx_valid    (spi_rx_valid),
        .spi_active      (spi_active)
    );

    // Free-running clock
    initial begin
        forever #5 clk = ~clk;
    end

    // Pulse counters observed on the active edge
    always @(posedge clk) begin
        if (wr_ready === 1'b1) wr_cnt <= wr_cnt + 1;
        if (rd_valid === 1'b1) rdv_cnt <= rdv_cnt + 1;
        if (rd_valid === 1'b1 && rd_last === 1'b1) rdl_cnt <= rdl_cnt + 1;
        if (done === 1'b1) done_cnt <= done_cnt + 1;
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic issue_cmd(input string tag, input logic rd, input logic [5:0] addr,
                             input logic [3:0] len);
        cmd_valid  = 1'b1;
        cmd_read   = rd;
        cmd_addr   = addr;
        cmd_len    = len;
        spi_active = 1'b1;
        #1 check_output({tag, " cmd_ready"}, cmd_ready, 1);
        tick();
        cmd_valid = 1'b0;
        check_output({tag, " hdr_latency"}, spi_tx_request, 1);
        check_output({tag, " busy"}, cmd_ready, 0);
    endtask

    task automatic wait_tx(input string tag, input logic [7:0] exp_data);
        int n = 0;
        while (spi_tx_request !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        check_output({tag, " tx_req"}, spi_tx_request, 1);
        check_output({tag, " tx_data"}, spi_tx_data, exp_data);
        check_output({tag, " no_rx"}, spi_rx_request, 0);
        spi_ack_request = 1'b1;
        tick();
        spi_ack_request = 1'b0;
        check_output({tag, " tx_drop"}, spi_tx_request, 0);
    endtask

    task automatic write_byte(input string tag, input logic [7:0] data, input int stall);
        for (int i = 0; i < stall; i++) begin
            tick();
            check_output({tag, " stall_tx"}, spi_tx_request, 0);
        end
        wr_valid = 1'b1;
        wr_data  = data;
        #1 check_output({tag, " wr_ready"}, wr_ready, 1);
        tick();
        wr_valid = 1'b0;
        wr_data  = 8'hxx;
        wait_tx(tag, data);
    endtask

    task automatic read_byte(input string tag, input logic [7:0] data, input logic last);
        int n = 0;
        while (spi_rx_request !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        check_output({tag, " rx_req"}, spi_rx_request, 1);
        check_output({tag, " no_tx"}, spi_tx_request, 0);
        spi_ack_request = 1'b1;
        tick();
        spi_ack_request = 1'b0;
        check_output({tag, " rx_drop"}, spi_rx_request, 0);
        tick();
        check_output({tag, " rx_hold"}, spi_rx_request, 0);
        spi_rx_data  = data;
        spi_rx_valid = 1'b1;
        tick();
        spi_rx_valid = 1'b0;
        check_output({tag, " rd_valid"}, rd_valid, 1);
        check_output({tag, " rd_data"}, rd_data, data);
        check_output({tag, " rd_last"}, rd_last, last);
    endtask

    task automatic finish_cmd(input string tag);
        tick();
        check_output({tag, " done_while_active"}, done, 0);
        spi_active = 1'b0;
        #1 check_output({tag, " done"}, done, 1);
        tick();
        check_output({tag, " done_pulse"}, done, 0);
        check_output({tag, " ready_after"}, cmd_ready, 1);
    endtask

    // Directed test sequence
    initial begin
        int w0, r0, l0, d0;
        reset           = 1'b1;
        cmd_valid       = 1'b0;
        cmd_read        = 1'b0;
        cmd_addr        = 6'h00;
        cmd_len         = 4'd0;
        wr_valid        = 1'b0;
        wr_data         = 8'h00;
        spi_ack_request = 1'b0;
        spi_rx_data     = 8'h00;
        spi_rx_valid    = 1'b0;
        spi_active      = 1'b0;
        tick();
        tick();
        check_output("reset cmd_ready", cmd_ready, 1);
        check_output("reset tx_req", spi_tx_request, 0);
        check_output("reset rx_req", spi_rx_request, 0);
        check_output("reset tx_data", spi_tx_data, 8'h00);
        check_output("reset rd_valid", rd_valid, 0);
        check_output("reset done", done, 0);
        check_output("reset error", error, 0);
        reset = 1'b0;
        tick();
        check_output("post reset cmd_ready", cmd_ready, 1);

        $display("[TB] test 1: write 0x15 len 1");
        w0 = wr_cnt; d0 = done_cnt;
        issue_cmd("t1", 1'b0, 6'h15, 4'd1);
        wait_tx("t1 hdr", 8'h15);
        write_byte("t1 b0", 8'h55, 2);
        finish_cmd("t1");
        check_output("t1 wr_ready count", wr_cnt - w0, 1);
        check_output("t1 done count", done_cnt - d0, 1);

        $display("[TB] test 2: read 0x15 len 1");
        r0 = rdv_cnt; l0 = rdl_cnt; d0 = done_cnt;
        issue_cmd("t2", 1'b1, 6'h15, 4'd1);
        wait_tx("t2 hdr", 8'h95);
        read_byte("t2 b0", 8'h3C, 1'b1);
        finish_cmd("t2");
        check_output("t2 rd_valid count", rdv_cnt - r0, 1);
        check_output("t2 rd_last count", rdl_cnt - l0, 1);
        check_output("t2 done count", done_cnt - d0, 1);

        $display("[TB] test 3: write 0x15 len 4");
        w0 = wr_cnt;
        issue_cmd("t3", 1'b0, 6'h15, 4'd4);
        wait_tx("t3 hdr", 8'h55);
        write_byte("t3 b0", 8'h55, 0);
        write_byte("t3 b1", 8'h55, 1);
        write_byte("t3 b2", 8'h55, 0);
        write_byte("t3 b3", 8'h55, 3);
        finish_cmd("t3");
        check_output("t3 wr_ready count", wr_cnt - w0, 4);

        $display("[TB] test 4: read 0x15 len 5");
        r0 = rdv_cnt; l0 = rdl_cnt; d0 = done_cnt;
        issue_cmd("t4", 1'b1, 6'h15, 4'd5);
        wait_tx("t4 hdr", 8'hD5);
        read_byte("t4 b0", 8'h10, 1'b0);
        read_byte("t4 b1", 8'h11, 1'b0);
        read_byte("t4 b2", 8'h12, 1'b0);
        read_byte("t4 b3", 8'h13, 1'b0);
        read_byte("t4 b4", 8'h14, 1'b1);
        finish_cmd("t4");
        check_output("t4 rd_valid count", rdv_cnt - r0, 5);
        check_output("t4 rd_last count", rdl_cnt - l0, 1);
        check_output("t4 done count", done_cnt - d0, 1);

        $display("[TB] test 5a: len 0 treated as 1");
        w0 = wr_cnt;
        issue_cmd("t5a", 1'b0, 6'h3F, 4'd0);
        wait_tx("t5a hdr", 8'h3F);
        write_byte("t5a b0", 8'hA5, 0);
        finish_cmd("t5a");
        check_output("t5a wr_ready count", wr_cnt - w0, 1);

        $display("[TB] test 5b: len 12 clamped to 8");
        w0 = wr_cnt;
        issue_cmd("t5b", 1'b0, 6'h01, 4'd12);
        wait_tx("t5b hdr", 8'h41);
        for (int i = 0; i < 8; i++) begin
            write_byte("t5b byte", 8'h20 + 8'(i), 0);
        end
        finish_cmd("t5b");
        check_output("t5b wr_ready count", wr_cnt - w0, 8);

        $display("[TB] test 6: reset in RD_WAIT of byte 2");
        d0 = done_cnt;
        issue_cmd("t6", 1'b1, 6'h15, 4'd3);
        wait_tx("t6 hdr", 8'hD5);
        read_byte("t6 b0", 8'h77, 1'b0);
        tick();
        check_output("t6 rx_req b1", spi_rx_request, 1);
        spi_ack_request = 1'b1;
        tick();
        spi_ack_request = 1'b0;
        reset = 1'b1;
        tick();
        check_output("t6 rx_req dropped", spi_rx_request, 0);
        check_output("t6 tx_req dropped", spi_tx_request, 0);
        check_output("t6 cmd_ready", cmd_ready, 1);
        check_output("t6 rd_valid", rd_valid, 0);
        reset      = 1'b0;
        spi_active = 1'b0;
        tick();
        tick();
        check_output("t6 no done", done_cnt - d0, 0);
        check_output("t6 idle ready", cmd_ready, 1);

`ifdef SPI_SEQ_TIMEOUT_EN
        $display("[TB] test 7: watchdog timeout with ack held low");
        begin
            int n;
            d0 = done_cnt;
            issue_cmd("t7", 1'b0, 6'h20, 4'd1);
            n = 1;
            while (done !== 1'b1 && n < 5000) begin
                tick();
                n++;
            end
            check_output("t7 done seen", done, 1);
            check_output("t7 timeout cycles", n, 4096);
            tick();
            check_output("t7 error", error, 1);
            check_output("t7 tx_req", spi_tx_request, 0);
            check_output("t7 cmd_ready", cmd_ready, 1);
            check_output("t7 done count", done_cnt - d0, 1);
            spi_active = 1'b0;
        end
`else
        check_output("error tied low", error, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
